// File: rtl/io_pkg.sv
// Shared encodings for the row DMA: FSM states, Wishbone cycle tags and
// transfer direction constants.
package io_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        MEM_RD,
        MEM_LAT,
        BUS,
        MEM_WR,
        FINISH
    } io_state_t;

    localparam logic [1:0] WB_SIMPLE_READ_CYCLE  = 2'd0;
    localparam logic [1:0] WB_SIMPLE_WRITE_CYCLE = 2'd1;

    localparam logic DIR_BUS_TO_MEM = 1'b0;
    localparam logic DIR_MEM_TO_BUS = 1'b1;

endpackage

// File: rtl/io_row_buffer.sv
// One memory row of ELEMENTS lanes. Lane 0 is the most significant slice,
// matching the data-memory row layout.
module io_row_buffer #(
    parameter int WIDTH    = 32,
    parameter int ELEMENTS = 3,
    parameter int LANE_W   = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic [ELEMENTS*WIDTH-1:0] row_in,
    input  logic                      lane_we,
    input  logic [LANE_W-1:0]         lane_sel,
    input  logic [WIDTH-1:0]          lane_in,
    output logic [ELEMENTS*WIDTH-1:0] row_out,
    output logic [WIDTH-1:0]          lane_out
);

    logic [ELEMENTS-1:0][WIDTH-1:0] row;
    logic [LANE_W-1:0]              idx;

    // Lane k lives at packed index ELEMENTS-1-k so that lane 0 is the MS slice.
    assign idx = LANE_W'(ELEMENTS - 1) - lane_sel;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row <= '0;
        end else if (load) begin
            row <= row_in;
        end else if (lane_we) begin
            row[idx] <= lane_in;
        end
    end

    assign row_out  = row;
    assign lane_out = row[idx];

endmodule

// File: rtl/io_row_dma.sv
// Single-channel DMA moving blocks of data-memory rows to/from a Wishbone bus,
// one lane per classic handshake, with optional bus-stall timeout.
module io_row_dma
    import io_pkg::*;
#(
    parameter int WIDTH              = 32,
    parameter int ELEMENTS           = 3,
    parameter int DATA_ADDRESS_WIDTH = 16,
    parameter int LEN_WIDTH          = 8,
    parameter int ADDR_STRIDE        = 1,
    parameter int TIMEOUT            = 255
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic                          iStart,
    input  logic                          iDir,
    input  logic [WIDTH-1:0]              iBusAddr,
    input  logic [DATA_ADDRESS_WIDTH-1:0] iMemAddr,
    input  logic [LEN_WIDTH-1:0]          iRowCount,
    output logic                          oBusy,
    output logic                          oDone,
    output logic                          oError,
    output logic [DATA_ADDRESS_WIDTH-1:0] oDataReadAddress,
    input  logic [ELEMENTS*WIDTH-1:0]     iReadDataBus,
    output logic [DATA_ADDRESS_WIDTH-1:0] oDataWriteAddress,
    output logic [ELEMENTS*WIDTH-1:0]     oDataBus,
    output logic                          oDataWriteEnable,
    output logic [WIDTH-1:0]              ADR_O,
    output logic [WIDTH-1:0]              DAT_O,
    input  logic [WIDTH-1:0]              DAT_I,
    output logic                          WE_O,
    output logic                          STB_O,
    output logic                          CYC_O,
    input  logic                          ACK_I,
    input  logic                          GNT_I,
    output logic [1:0]                    TGC_O
);

    localparam int LANE_W = (ELEMENTS > 1) ? $clog2(ELEMENTS) : 1;
    localparam int TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(ELEMENTS - 1);
    localparam logic [TW-1:0]     TMO_LAST  = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    io_state_t state, nstate;

    logic                          dir;
    logic [WIDTH-1:0]              bus_addr;
    logic [DATA_ADDRESS_WIDTH-1:0] mem_row;
    logic [LEN_WIDTH-1:0]          remaining;
    logic [LANE_W-1:0]             lane;
    logic                          gap;
    logic                          row_end;
    logic                          error;
    logic [TW-1:0]                 tcnt;

    logic start_acc, stb, cyc, wen, done;
    logic ack_take, stall, tmo, row_done, load_row;
    logic last_row;

    logic [WIDTH-1:0]          lane_out;
    logic [ELEMENTS*WIDTH-1:0] row_out;

    assign last_row = (remaining == LEN_WIDTH'(1));

    // BUS alternates strobe and idle (gap) cycles; the row-level decision is
    // taken in the gap following the last lane's ACK.
    always_comb begin
        nstate    = state;
        start_acc = 1'b0;
        stb       = 1'b0;
        cyc       = 1'b0;
        wen       = 1'b0;
        done      = 1'b0;
        ack_take  = 1'b0;
        stall     = 1'b0;
        tmo       = 1'b0;
        row_done  = 1'b0;
        load_row  = 1'b0;
        unique case (state)
            IDLE: begin
                if (iStart) begin
                    start_acc = 1'b1;
                    nstate    = (iRowCount == '0) ? FINISH : REQ;
                end
            end
            REQ: begin
                cyc = 1'b1;
                if (GNT_I) nstate = (dir == DIR_MEM_TO_BUS) ? MEM_RD : BUS;
            end
            MEM_RD: begin
                cyc    = 1'b1;
                nstate = MEM_LAT;
            end
            MEM_LAT: begin
                cyc      = 1'b1;
                load_row = 1'b1;
                nstate   = BUS;
            end
            BUS: begin
                cyc = 1'b1;
                if (gap) begin
                    if (row_end) begin
                        if (dir == DIR_BUS_TO_MEM) begin
                            nstate = MEM_WR;
                        end else begin
                            row_done = 1'b1;
                            nstate   = last_row ? FINISH : MEM_RD;
                        end
                    end
                end else begin
                    stb = 1'b1;
                    if (ACK_I) begin
                        ack_take = 1'b1;
                    end else if (TIMEOUT != 0 && tcnt == TMO_LAST) begin
                        tmo    = 1'b1;
                        nstate = FINISH;
                    end else begin
                        stall = 1'b1;
                    end
                end
            end
            MEM_WR: begin
                cyc      = 1'b1;
                wen      = 1'b1;
                row_done = 1'b1;
                nstate   = last_row ? FINISH : BUS;
            end
            FINISH: begin
                done   = 1'b1;
                nstate = IDLE;
            end
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state     <= IDLE;
            dir       <= 1'b0;
            bus_addr  <= '0;
            mem_row   <= '0;
            remaining <= '0;
            lane      <= '0;
            gap       <= 1'b0;
            row_end   <= 1'b0;
            tcnt      <= '0;
            error     <= 1'b0;
        end else begin
            state <= nstate;
            if (start_acc) begin
                dir       <= iDir;
                bus_addr  <= iBusAddr;
                mem_row   <= iMemAddr;
                remaining <= iRowCount;
                lane      <= '0;
                gap       <= 1'b0;
                row_end   <= 1'b0;
                tcnt      <= '0;
                error     <= 1'b0;
            end
            if (ack_take) begin
                bus_addr <= bus_addr + WIDTH'(ADDR_STRIDE);
                tcnt     <= '0;
                gap      <= 1'b1;
                row_end  <= (lane == LANE_LAST);
                lane     <= (lane == LANE_LAST) ? '0 : lane + 1'b1;
            end
            if (stall && TIMEOUT != 0) tcnt <= tcnt + 1'b1;
            if (tmo) begin
                tcnt  <= '0;
                error <= 1'b1;
            end
            if (state == BUS && gap) begin
                gap     <= 1'b0;
                row_end <= 1'b0;
            end
            if (row_done) begin
                mem_row   <= mem_row + 1'b1;
                remaining <= remaining - 1'b1;
            end
        end
    end

    io_row_buffer #(
        .WIDTH    (WIDTH),
        .ELEMENTS (ELEMENTS),
        .LANE_W   (LANE_W)
    ) u_buf (
        .clk      (Clock),
        .rst_n    (Reset),
        .load     (load_row),
        .row_in   (iReadDataBus),
        .lane_we  (ack_take && dir == DIR_BUS_TO_MEM),
        .lane_sel (lane),
        .lane_in  (DAT_I),
        .row_out  (row_out),
        .lane_out (lane_out)
    );

    assign oBusy             = (state != IDLE);
    assign oDone             = done;
    assign oError            = error;
    assign oDataReadAddress  = mem_row;
    assign oDataWriteAddress = mem_row;
    assign oDataBus          = row_out;
    assign oDataWriteEnable  = wen;
    assign ADR_O             = stb ? bus_addr : '0;
    assign DAT_O             = (stb && dir == DIR_MEM_TO_BUS) ? lane_out : '0;
    assign WE_O              = dir;
    assign STB_O             = stb;
    assign CYC_O             = cyc;
    assign TGC_O             = (dir == DIR_MEM_TO_BUS) ? WB_SIMPLE_WRITE_CYCLE : WB_SIMPLE_READ_CYCLE;

endmodule

// File: tb/tb_io_row_dma.sv
// Directed bench for io_row_dma: Wishbone slave and data-memory models
// respond on the falling edge; expected values are hand-derived constants.
module tb_io_row_dma;

    localparam int WIDTH    = 32;
    localparam int ELEMENTS = 3;
    localparam int DAW      = 16;
    localparam int LENW     = 8;

    logic                      Clock = 1'b0;
    logic                      Reset = 1'b0;
    logic                      iStart = 1'b0;
    logic                      iDir = 1'b0;
    logic [WIDTH-1:0]          iBusAddr = '0;
    logic [DAW-1:0]            iMemAddr = '0;
    logic [LENW-1:0]           iRowCount = '0;
    logic                      oBusy, oDone, oError;
    logic [DAW-1:0]            oDataReadAddress, oDataWriteAddress;
    logic [ELEMENTS*WIDTH-1:0] iReadDataBus = '0;
    logic [ELEMENTS*WIDTH-1:0] oDataBus;
    logic                      oDataWriteEnable;
    logic [WIDTH-1:0]          ADR_O, DAT_O;
    logic [WIDTH-1:0]          DAT_I = '0;
    logic                      WE_O, STB_O, CYC_O;
    logic                      ACK_I = 1'b0;
    logic                      GNT_I = 1'b1;
    logic [1:0]                TGC_O;

    io_row_dma #(
        .WIDTH(WIDTH), .ELEMENTS(ELEMENTS), .DATA_ADDRESS_WIDTH(DAW),
        .LEN_WIDTH(LENW), .ADDR_STRIDE(1), .TIMEOUT(4)
    ) dut (
        .Clock(Clock), .Reset(Reset), .iStart(iStart), .iDir(iDir),
        .iBusAddr(iBusAddr), .iMemAddr(iMemAddr), .iRowCount(iRowCount),
        .oBusy(oBusy), .oDone(oDone), .oError(oError),
        .oDataReadAddress(oDataReadAddress), .iReadDataBus(iReadDataBus),
        .oDataWriteAddress(oDataWriteAddress), .oDataBus(oDataBus),
        .oDataWriteEnable(oDataWriteEnable), .ADR_O(ADR_O), .DAT_O(DAT_O),
        .DAT_I(DAT_I), .WE_O(WE_O), .STB_O(STB_O), .CYC_O(CYC_O),
        .ACK_I(ACK_I), .GNT_I(GNT_I), .TGC_O(TGC_O)
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    logic [ELEMENTS*WIDTH-1:0] mem [64];

    int  ack_lat = 1;
    bit  ack_en = 1'b1;
    int  wait_cnt, stb_cycles, stb_no_gnt, cyc_seen, n_wen, n_done;
    int  first_stb, first_cyc, first_wen, done_at, t0;
    logic [WIDTH-1:0] q_adr[$], q_dat[$];
    logic             q_we[$];
    logic [1:0]       q_tgc[$];
    logic [DAW-1:0]   q_wadr[$];

    // Bus slave + synchronous-read memory model.
    always @(negedge Clock) begin
        iReadDataBus = mem[oDataReadAddress[5:0]];
        ACK_I = 1'b0;
        if (STB_O) begin
            stb_cycles++;
            if (first_stb < 0) first_stb = cyc;
            if (!GNT_I) stb_no_gnt++;
            if (ack_en && wait_cnt + 1 >= ack_lat) begin
                ACK_I = 1'b1;
                wait_cnt = 0;
                DAT_I = ADR_O;
                q_adr.push_back(ADR_O);
                q_dat.push_back(DAT_O);
                q_we.push_back(WE_O);
                q_tgc.push_back(TGC_O);
            end else begin
                wait_cnt++;
            end
        end
        if (CYC_O) begin
            cyc_seen++;
            if (first_cyc < 0) first_cyc = cyc;
        end
        if (oDataWriteEnable) begin
            mem[oDataWriteAddress[5:0]] = oDataBus;
            q_wadr.push_back(oDataWriteAddress);
            n_wen++;
            if (first_wen < 0) first_wen = cyc;
        end
        if (oDone) begin
            n_done++;
            done_at = cyc;
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear();
        q_adr.delete(); q_dat.delete(); q_we.delete(); q_tgc.delete(); q_wadr.delete();
        wait_cnt = 0; stb_cycles = 0; stb_no_gnt = 0; cyc_seen = 0; n_wen = 0; n_done = 0;
        first_stb = -1; first_cyc = -1; first_wen = -1; done_at = -1;
    endtask

    task automatic start(input logic dir, input logic [WIDTH-1:0] badr,
                         input logic [DAW-1:0] madr, input logic [LENW-1:0] rows, input int hold);
        @(negedge Clock);
        iDir = dir; iBusAddr = badr; iMemAddr = madr; iRowCount = rows;
        iStart = 1'b1;
        t0 = cyc;
        repeat (hold) @(negedge Clock);
        iStart = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (oBusy && n < 300) begin
            @(negedge Clock);
            n++;
        end
        repeat (2) @(negedge Clock);
        chk({tag, "_bounded"}, n < 300, 1);
    endtask

    task automatic wait_stb(input logic lvl);
        int n;
        n = 0;
        while (STB_O !== lvl && n < 50) begin
            @(negedge Clock);
            #1;
            n++;
        end
        chk("wait_stb_bounded", n < 50, 1);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        clear();

        // Reset state
        repeat (3) @(negedge Clock);
        chk("reset_ctrl", {oBusy, oDone, oError, STB_O, CYC_O, WE_O, oDataWriteEnable}, 0);
        chk("reset_adr", ADR_O, 0);
        Reset = 1'b1;
        repeat (2) @(negedge Clock);

        // Read, 2 rows, zero-wait ACK
        clear();
        start(1'b0, 32'h100, 16'd5, 8'd2, 1);
        wait_idle("rd2");
        chk("rd2_row5", mem[5], {32'h100, 32'h101, 32'h102});
        chk("rd2_row6", mem[6], {32'h103, 32'h104, 32'h105});
        chk("rd2_wen_count", n_wen, 2);
        chk("rd2_done_count", n_done, 1);
        chk("rd2_first_stb", first_stb - t0, 2);
        chk("rd2_first_wen", first_wen - t0, 8);
        chk("rd2_done_at", done_at - t0, 16);
        chk("rd2_adr_last", q_adr.size() == 6 ? q_adr[5] : 32'hX, 32'h105);
        chk("rd2_tgc", q_tgc.size() > 0 ? q_tgc[0] : 2'bx, 2'd0);
        chk("rd2_error", oError, 0);

        // Write, 1 row
        mem[9] = {32'hA, 32'hB, 32'hC};
        clear();
        start(1'b1, 32'h200, 16'd9, 8'd1, 1);
        wait_idle("wr1");
        chk("wr1_count", q_adr.size(), 3);
        for (int i = 0; i < 3 && i < q_adr.size(); i++) begin
            chk($sformatf("wr1_adr%0d", i), q_adr[i], 32'h200 + i);
            chk($sformatf("wr1_dat%0d", i), q_dat[i], 32'hA + i);
            chk($sformatf("wr1_we%0d", i), q_we[i], 1);
        end
        chk("wr1_tgc", q_tgc.size() > 0 ? q_tgc[0] : 2'bx, 2'd1);
        chk("wr1_no_memwr", n_wen, 0);
        chk("wr1_done_at", done_at - t0, 10);

        // Grant delay and 3-cycle ACK latency
        GNT_I = 1'b0;
        ack_lat = 3;
        clear();
        start(1'b0, 32'h300, 16'd12, 8'd1, 1);
        repeat (10) @(negedge Clock);
        GNT_I = 1'b1;
        wait_idle("gnt");
        chk("gnt_cyc_first", first_cyc - t0, 1);
        chk("gnt_no_stb_early", stb_no_gnt, 0);
        chk("gnt_stb_after_grant", first_stb - t0 > 10, 1);
        chk("gnt_stb_cycles", stb_cycles, 9);
        chk("gnt_row12", mem[12], {32'h300, 32'h301, 32'h302});
        ack_lat = 1;

        // Timeout: no ACK at all
        mem[14] = {32'hDEAD, 32'hBEEF, 32'hCAFE};
        ack_en = 1'b0;
        clear();
        start(1'b0, 32'h400, 16'd14, 8'd1, 1);
        wait_idle("tmo");
        chk("tmo_stb_cycles", stb_cycles, 4);
        chk("tmo_cyc_cycles", cyc_seen, 5);
        chk("tmo_error", oError, 1);
        chk("tmo_done_count", n_done, 1);
        chk("tmo_done_at", done_at - t0, 6);
        chk("tmo_no_memwr", n_wen, 0);
        chk("tmo_mem_kept", mem[14], {32'hDEAD, 32'hBEEF, 32'hCAFE});
        ack_en = 1'b1;

        // Zero length; iStart held into the FINISH cycle must not restart
        clear();
        start(1'b0, 32'h500, 16'd20, 8'd0, 2);
        wait_idle("zero");
        repeat (3) @(negedge Clock);
        chk("zero_no_cyc", cyc_seen, 0);
        chk("zero_done_count", n_done, 1);
        chk("zero_done_lat", done_at - t0 <= 2 && done_at - t0 >= 1, 1);
        chk("zero_error_cleared", oError, 0);

        // Reset during the second element
        clear();
        start(1'b0, 32'h600, 16'd22, 8'd1, 1);
        wait_stb(1'b1);
        wait_stb(1'b0);
        ack_en = 1'b0;
        wait_stb(1'b1);
        chk("rst_mid_one_ack", q_adr.size(), 1);
        Reset = 1'b0;
        @(negedge Clock);
        #1;
        chk("rst_mid_ctrl", {oBusy, oDone, oError, STB_O, CYC_O, WE_O, oDataWriteEnable}, 0);
        chk("rst_mid_adr", ADR_O, 0);
        chk("rst_mid_row", oDataBus, 0);
        chk("rst_mid_raddr", oDataReadAddress, 0);
        @(negedge Clock);
        Reset = 1'b1;
        ack_en = 1'b1;
        repeat (5) @(negedge Clock);
        chk("rst_mid_no_done", n_done, 0);

        // Bus address and memory row wrap
        clear();
        start(1'b0, 32'hFFFF_FFFE, 16'hFFFF, 8'd2, 1);
        wait_idle("wrap");
        chk("wrap_adr_count", q_adr.size(), 6);
        chk("wrap_adr2", q_adr.size() > 2 ? q_adr[2] : 32'hX, 32'h0);
        chk("wrap_row63", mem[63], {32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0});
        chk("wrap_row0", mem[0], {32'h1, 32'h2, 32'h3});
        chk("wrap_wadr0", q_wadr.size() > 0 ? q_wadr[0] : 16'hX, 16'hFFFF);
        chk("wrap_wadr1", q_wadr.size() > 1 ? q_wadr[1] : 16'hX, 16'h0);
        chk("wrap_done_count", n_done, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
